// File: rtl/local_mem_arbiter.sv
// Two-port arbiter for a single-ported local memory: port 0 fixed priority, bounded port-1 starvation, lock support.
// Optional stall counters enabled by defining LOCAL_MEM_ARB_PERF_EN.
module local_mem_arbiter #(
    parameter int unsigned ADDR_W       = 30,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    output logic              p0_ready,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [3:0]        p0_be,
    input  logic [31:0]       p0_wdata,
    input  logic              p0_lock,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    input  logic              p1_req,
    output logic              p1_ready,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [3:0]        p1_be,
    input  logic [31:0]       p1_wdata,
    input  logic              p1_lock,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out,
    output logic [31:0]       p0_stall_cnt,
    output logic [31:0]       p1_stall_cnt
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic             grant0, grant1, force1;

    // Lock owner wins if it still requests; otherwise fall through to normal arbitration.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_nxt  = ARB;
        starve_nxt = starve_cnt;
        force1     = (starve_cnt == CNT_W'(STARVE_LIMIT)) && p1_req;

        if (state == LOCK0 && p0_req) begin
            grant0 = 1'b1;
        end else if (state == LOCK1 && p1_req) begin
            grant1 = 1'b1;
        end else if (p0_req && !force1) begin
            grant0 = 1'b1;
        end else if (p1_req) begin
            grant1 = 1'b1;
        end

        if (grant0 && p0_lock) begin
            state_nxt = LOCK0;
        end else if (grant1 && p1_lock) begin
            state_nxt = LOCK1;
        end

        // Only unlocked port-0 wins count toward starving port 1.
        if (grant1 || !p1_req) begin
            starve_nxt = '0;
        end else if (grant0 && state == ARB && starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end
    end

    assign p0_ready    = grant0;
    assign p1_ready    = grant1;
    assign mem_en      = grant0 | grant1;
    assign mem_addr    = grant1 ? p1_addr  : p0_addr;
    assign mem_data_in = grant1 ? p1_wdata : p0_wdata;
    assign mem_be      = grant0 ? p0_be : (grant1 ? p1_be : 4'b0000);
    assign p0_rdata    = mem_data_out;
    assign p1_rdata    = mem_data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= '0;
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            p0_rvalid  <= grant0 && (p0_be == 4'b0000);
            p1_rvalid  <= grant1 && (p1_be == 4'b0000);
        end
    end

`ifdef LOCAL_MEM_ARB_PERF_EN
    // Cycles each port spent requesting without being granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_stall_cnt <= 32'd0;
            p1_stall_cnt <= 32'd0;
        end else begin
            if (p0_req && !grant0) p0_stall_cnt <= p0_stall_cnt + 32'd1;
            if (p1_req && !grant1) p1_stall_cnt <= p1_stall_cnt + 32'd1;
        end
    end
`else
    assign p0_stall_cnt = 32'd0;
    assign p1_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_local_mem_arbiter.sv
// Scoreboard bench for local_mem_arbiter: stimulus queues expected grants/read returns, a negedge monitor checks them.
module tb_local_mem_arbiter;

    localparam int unsigned ADDR_W       = 30;
    localparam int unsigned STARVE_LIMIT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p0_ready, p0_lock, p0_rvalid;
    logic [ADDR_W-1:0] p0_addr;
    logic [3:0]        p0_be;
    logic [31:0]       p0_wdata, p0_rdata, p0_stall_cnt;
    logic              p1_req, p1_ready, p1_lock, p1_rvalid;
    logic [ADDR_W-1:0] p1_addr;
    logic [3:0]        p1_be;
    logic [31:0]       p1_wdata, p1_rdata, p1_stall_cnt;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_data_in;
    logic [31:0]       mem_data_out = 32'd0;

    local_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_be(p0_be),
        .p0_wdata(p0_wdata), .p0_lock(p0_lock), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_be(p1_be),
        .p1_wdata(p1_wdata), .p1_lock(p1_lock), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_be(mem_be), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out),
        .p0_stall_cnt(p0_stall_cnt), .p1_stall_cnt(p1_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int unsigned       cyc;
        logic              port;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       wdata;
    } gnt_t;

    typedef struct packed {
        int unsigned cyc;
        logic        port;
        logic [31:0] data;
    } rd_t;

    gnt_t        gnt_q[$];
    rd_t         rd_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    bit          mon_en = 1'b0;
    logic [31:0] mem [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 1-cycle read latency, byte-enabled writes, contents restored on reset.
    always @(posedge clk) begin
        if (rst && !mon_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            mem[16] <= 32'hDEAD_BEEF;
        end else if (mem_en) begin
            if (mem_be == 4'b0000) mem_data_out <= mem[mem_addr[7:0]];
            else for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_data_in[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic obs_gnt(input logic port);
        gnt_t o;
        o = '{cyc, port, mem_addr, mem_be, mem_data_in};
        chk("grant_mem_en", 128'(mem_en), 128'(1));
        if (gnt_q.size() == 0) chk("unexpected_grant", 128'(o), 128'(0));
        else chk("grant", 128'(o), 128'(gnt_q.pop_front()));
    endtask

    task automatic obs_rd(input logic port, input logic [31:0] data);
        rd_t o;
        o = '{cyc, port, data};
        if (rd_q.size() == 0) chk("unexpected_rvalid", 128'(o), 128'(0));
        else chk("read_return", 128'(o), 128'(rd_q.pop_front()));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("grant_onehot", 128'(p0_ready & p1_ready), 128'(0));
            if (p0_ready) obs_gnt(1'b0);
            if (p1_ready) obs_gnt(1'b1);
            if (!p0_ready && !p1_ready) chk("idle_bus", 128'({mem_en, mem_be}), 128'(0));
            if (p0_rvalid) obs_rd(1'b0, p0_rdata);
            if (p1_rvalid) obs_rd(1'b1, p1_rdata);
        end
    end

    // One cycle of stimulus; port 1 never writes so its wdata stays 0.
    task automatic drv(input logic r0, input logic l0, input logic [ADDR_W-1:0] a0,
                       input logic [3:0] b0, input logic [31:0] w0,
                       input logic r1, input logic l1, input logic [ADDR_W-1:0] a1);
        @(posedge clk);
        #1;
        p0_req = r0; p0_lock = l0; p0_addr = a0; p0_be = b0; p0_wdata = w0;
        p1_req = r1; p1_lock = l1; p1_addr = a1; p1_be = 4'b0000; p1_wdata = 32'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, '0, 4'b0, 32'd0, 0, 0, '0);
    endtask

    task automatic eg(input logic port, input logic [ADDR_W-1:0] a, input logic [3:0] b, input logic [31:0] w);
        gnt_q.push_back('{cyc, port, a, b, w});
    endtask

    task automatic er(input logic port, input logic [31:0] d);
        rd_q.push_back('{cyc + 1, port, d});
    endtask

    logic [31:0] s0, s1;

    initial begin
        rst = 1'b1;
        p0_req = 0; p0_lock = 0; p0_addr = '0; p0_be = '0; p0_wdata = '0;
        p1_req = 0; p1_lock = 0; p1_addr = '0; p1_be = '0; p1_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_p0_rvalid", 128'(p0_rvalid), 128'(0));
        chk("reset_p1_rvalid", 128'(p1_rvalid), 128'(0));
        chk("reset_mem_en", 128'(mem_en), 128'(0));
        chk("reset_p0_stall", 128'(p0_stall_cnt), 128'(0));
        chk("reset_p1_stall", 128'(p1_stall_cnt), 128'(0));
        mon_en = 1'b1;
        idle(1);

        // Basic read.
        drv(1, 0, 'h10, 4'h0, 32'd0, 0, 0, '0); eg(0, 'h10, 4'h0, 32'd0); er(0, 32'hDEAD_BEEF);
        idle(2);

        // Starvation bound with both ports hammering: p0,p0,p1,p0,p0,p1.
        for (int i = 0; i < 6; i++) begin
            drv(1, 0, 'h11, 4'h0, 32'd0, 1, 0, 'h12);
            if (i % 3 == 2) begin eg(1, 'h12, 4'h0, 32'd0); er(1, 32'hA000_0012); end
            else begin eg(0, 'h11, 4'h0, 32'd0); er(0, 32'hA000_0011); end
        end
        idle(2);

        // Locked read-modify-write holds port 1 off for both cycles.
        drv(1, 1, 'h20, 4'h0, 32'd0, 1, 0, 'h21); eg(0, 'h20, 4'h0, 32'd0); er(0, 32'hA000_0020);
        drv(1, 0, 'h20, 4'hF, 32'd5, 1, 0, 'h21); eg(0, 'h20, 4'hF, 32'd5);
        drv(0, 0, '0, 4'h0, 32'd0, 1, 0, 'h21);   eg(1, 'h21, 4'h0, 32'd0); er(1, 32'hA000_0021);
        drv(1, 0, 'h20, 4'h0, 32'd0, 0, 0, '0);   eg(0, 'h20, 4'h0, 32'd0); er(0, 32'd5);
        idle(2);

        // Lock dropped by an idle owner; starvation counting resumes in ARB.
        drv(1, 1, 'h30, 4'h0, 32'd0, 0, 0, '0);   eg(0, 'h30, 4'h0, 32'd0); er(0, 32'hA000_0030);
        drv(0, 0, '0, 4'h0, 32'd0, 1, 0, 'h31);   eg(1, 'h31, 4'h0, 32'd0); er(1, 32'hA000_0031);
        for (int i = 0; i < 2; i++) begin
            drv(1, 0, 'h32, 4'h0, 32'd0, 1, 0, 'h31); eg(0, 'h32, 4'h0, 32'd0); er(0, 32'hA000_0032);
        end
        drv(1, 0, 'h32, 4'h0, 32'd0, 1, 0, 'h31); eg(1, 'h31, 4'h0, 32'd0); er(1, 32'hA000_0031);
        idle(2);

        // Reset in a LOCK0 cycle: grant seen, rvalid suppressed, counter and lock cleared.
        drv(1, 0, 'h40, 4'h0, 32'd0, 1, 0, 'h42); eg(0, 'h40, 4'h0, 32'd0); er(0, 32'hA000_0040);
        drv(1, 1, 'h40, 4'h0, 32'd0, 1, 0, 'h42); eg(0, 'h40, 4'h0, 32'd0); er(0, 32'hA000_0040);
        drv(1, 1, 'h41, 4'h0, 32'd0, 1, 0, 'h42); rst = 1'b1; eg(0, 'h41, 4'h0, 32'd0);
        drv(1, 0, 'h43, 4'h0, 32'd0, 1, 0, 'h42); rst = 1'b0; eg(0, 'h43, 4'h0, 32'd0); er(0, 32'hA000_0043);
        drv(1, 0, 'h43, 4'h0, 32'd0, 1, 0, 'h42); eg(0, 'h43, 4'h0, 32'd0); er(0, 32'hA000_0043);
        drv(1, 0, 'h43, 4'h0, 32'd0, 1, 0, 'h42); eg(1, 'h42, 4'h0, 32'd0); er(1, 32'hA000_0042);
        idle(2);

        // Port 1 blocked three cycles by a locked port-0 burst.
        @(negedge clk);
        s0 = p0_stall_cnt;
        s1 = p1_stall_cnt;
        drv(1, 1, 'h50, 4'h0, 32'd0, 1, 0, 'h51); eg(0, 'h50, 4'h0, 32'd0); er(0, 32'hA000_0050);
        drv(1, 1, 'h52, 4'h0, 32'd0, 1, 0, 'h51); eg(0, 'h52, 4'h0, 32'd0); er(0, 32'hA000_0052);
        drv(1, 0, 'h53, 4'h0, 32'd0, 1, 0, 'h51); eg(0, 'h53, 4'h0, 32'd0); er(0, 32'hA000_0053);
        drv(0, 0, '0, 4'h0, 32'd0, 1, 0, 'h51);   eg(1, 'h51, 4'h0, 32'd0); er(1, 32'hA000_0051);
        idle(2);
        @(negedge clk);
`ifdef LOCAL_MEM_ARB_PERF_EN
        chk("p1_stall_delta", 128'(p1_stall_cnt - s1), 128'(3));
        chk("p0_stall_delta", 128'(p0_stall_cnt - s0), 128'(0));
`else
        chk("p1_stall_tied", 128'({s1, p1_stall_cnt}), 128'(0));
        chk("p0_stall_tied", 128'({s0, p0_stall_cnt}), 128'(0));
`endif

        idle(3);
        @(negedge clk);
        chk("grant_queue_drained", 128'(gnt_q.size()), 128'(0));
        chk("read_queue_drained", 128'(rd_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
